// File: rtl/mempool_pkg.sv
// ============================================================================
// Module : mempool_pkg
// Brief  : Shared TCDM types, AMO encoding and LR/SC reservation record.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mempool_pkg;

    localparam int unsigned NumBanksPerTile  = 16;
    localparam int unsigned TCDMAddrMemWidth = 8;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

    localparam int unsigned TileAddrWidth = TCDMAddrMemWidth + idx_width(NumBanksPerTile);

    typedef logic [TileAddrWidth-1:0]    tile_addr_t;
    typedef logic [TCDMAddrMemWidth-1:0] bank_row_t;
    typedef logic [5:0]                  meta_id_t;
    typedef logic [3:0]                  core_id_t;
    typedef logic [3:0]                  ini_addr_t;
    typedef logic [3:0]                  strb_t;

    // Codes 0xC..0xF are unnamed and decode as AMO_NONE.
    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_SWAP = 4'h1,
        AMO_ADD  = 4'h2,
        AMO_AND  = 4'h3,
        AMO_OR   = 4'h4,
        AMO_XOR  = 4'h5,
        AMO_MAX  = 4'h6,
        AMO_MAXU = 4'h7,
        AMO_MIN  = 4'h8,
        AMO_MINU = 4'h9,
        AMO_LR   = 4'hA,
        AMO_SC   = 4'hB
    } amo_t;

    typedef struct packed {
        meta_id_t    meta_id;
        core_id_t    core_id;
        amo_t        amo;
        logic [31:0] data;
    } tcdm_payload_t;

    typedef struct packed {
        tcdm_payload_t wdata;
        logic          wen;
        strb_t         be;
        tile_addr_t    tgt_addr;
        ini_addr_t     ini_addr;
    } tcdm_slave_req_t;

    typedef struct packed {
        tcdm_payload_t rdata;
        ini_addr_t     ini_addr;
    } tcdm_slave_resp_t;

    typedef struct packed {
        logic      valid;
        bank_row_t row;
        ini_addr_t ini_addr;
        core_id_t  core_id;
    } amo_resv_t;

endpackage

`default_nettype wire

// File: rtl/tcdm_amo_alu.sv
// ============================================================================
// Module : tcdm_amo_alu
// Brief  : Combinational read-modify-write function for TCDM atomics.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tcdm_amo_alu
    import mempool_pkg::*;
(
    input  amo_t        op,
    input  logic [31:0] old,
    input  logic [31:0] operand,
    output logic [31:0] result
);

    always_comb begin
        result = old;
        case (op)
            AMO_SWAP: result = operand;
            AMO_ADD:  result = old + operand;
            AMO_AND:  result = old & operand;
            AMO_OR:   result = old | operand;
            AMO_XOR:  result = old ^ operand;
            AMO_MAX:  result = ($signed(old) > $signed(operand)) ? old : operand;
            AMO_MAXU: result = (old > operand) ? old : operand;
            AMO_MIN:  result = ($signed(old) < $signed(operand)) ? old : operand;
            AMO_MINU: result = (old < operand) ? old : operand;
            default:  result = old;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tcdm_amo_shim.sv
// ============================================================================
// Module : tcdm_amo_shim
// Brief  : Single-outstanding TCDM bank front end with atomics; LR/SC
//          reservation enabled by defining TCDM_AMO_LRSC_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tcdm_amo_shim
    import mempool_pkg::*;
#(
    parameter int unsigned BankRowWidth = TCDMAddrMemWidth,
    parameter int unsigned BankSelWidth = idx_width(NumBanksPerTile)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  tcdm_slave_req_t         in_req_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output tcdm_slave_resp_t        out_resp_o,
    output logic                    bank_req_o,
    output logic                    bank_we_o,
    output logic [BankRowWidth-1:0] bank_addr_o,
    output logic [31:0]             bank_wdata_o,
    output logic [3:0]              bank_be_o,
    input  logic [31:0]             bank_rdata_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        AMO_RD    = 2'd1,
        RESP_HOLD = 2'd2
    } state_t;

    state_t                  r_state, w_state_next;
    logic                    r_out_valid, r_data_live;
    tcdm_slave_resp_t        r_resp;
    amo_t                    r_pend_op;
    logic [BankRowWidth-1:0] r_pend_row;
    logic [31:0]             r_pend_operand;
    meta_id_t                r_pend_meta;
    core_id_t                r_pend_core;
    ini_addr_t               r_pend_ini;

    logic [BankRowWidth-1:0] w_row;
    logic [31:0]             w_alu_result;
    logic w_resp_free, w_accept, w_is_amo, w_is_lr, w_is_sc, w_is_load, w_is_store, w_sc_ok;

    assign w_row       = BankRowWidth'(in_req_i.tgt_addr >> BankSelWidth);
    assign w_resp_free = !r_out_valid || out_ready_i;
    assign in_ready_o  = !rst_i && (r_state == IDLE) && w_resp_free;
    assign w_accept    = in_valid_i && in_ready_o;

    assign w_is_amo   = (in_req_i.wdata.amo >= AMO_SWAP) && (in_req_i.wdata.amo <= AMO_MINU);
    assign w_is_lr    = (in_req_i.wdata.amo == AMO_LR);
    assign w_is_sc    = (in_req_i.wdata.amo == AMO_SC);
    assign w_is_load  = !w_is_amo && !w_is_sc && (w_is_lr || !in_req_i.wen);
    assign w_is_store = !w_is_amo && !w_is_sc && !w_is_lr && in_req_i.wen;

`ifdef TCDM_AMO_LRSC_EN
    amo_resv_t r_resv;

    assign w_sc_ok = r_resv.valid
                  && (r_resv.row == bank_row_t'(w_row))
                  && (r_resv.ini_addr == in_req_i.ini_addr)
                  && (r_resv.core_id == in_req_i.wdata.core_id);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resv <= '0;
        end else begin
            if ((r_state == AMO_RD) && (r_resv.row == bank_row_t'(r_pend_row))) begin
                r_resv.valid <= 1'b0;
            end
            if (w_accept) begin
                if ((w_is_store && (r_resv.row == bank_row_t'(w_row))) || w_is_sc) begin
                    r_resv.valid <= 1'b0;
                end
                if (w_is_lr) begin
                    r_resv <= '{valid: 1'b1, row: bank_row_t'(w_row),
                                ini_addr: in_req_i.ini_addr, core_id: in_req_i.wdata.core_id};
                end
            end
        end
    end
`else
    assign w_sc_ok = 1'b0;
`endif

    tcdm_amo_alu u_alu (
        .op      (r_pend_op),
        .old     (bank_rdata_i),
        .operand (r_pend_operand),
        .result  (w_alu_result)
    );

    always_comb begin
        w_state_next = r_state;
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        case (r_state)
            IDLE: begin
                if (!w_resp_free) begin
                    w_state_next = RESP_HOLD;
                end else if (in_valid_i) begin
                    if (w_is_amo) begin
                        bank_req_o   = 1'b1;
                        bank_addr_o  = w_row;
                        bank_be_o    = 4'hF;
                        w_state_next = AMO_RD;
                    end else if (w_is_load || w_is_store || w_sc_ok) begin
                        bank_req_o   = 1'b1;
                        bank_we_o    = !w_is_load;
                        bank_addr_o  = w_row;
                        bank_wdata_o = w_is_load ? 32'd0 : in_req_i.wdata.data;
                        bank_be_o    = in_req_i.be;
                    end
                end
            end
            AMO_RD: begin
                bank_req_o   = 1'b1;
                bank_we_o    = 1'b1;
                bank_addr_o  = r_pend_row;
                bank_wdata_o = w_alu_result;
                bank_be_o    = 4'hF;
                w_state_next = IDLE;
            end
            RESP_HOLD: begin
                if (out_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        // An asserted reset must silence the bank even before the next edge.
        if (rst_i) begin
            bank_req_o   = 1'b0;
            bank_we_o    = 1'b0;
            bank_addr_o  = '0;
            bank_wdata_o = '0;
            bank_be_o    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_out_valid    <= 1'b0;
            r_data_live    <= 1'b0;
            r_resp         <= '0;
            r_pend_op      <= AMO_NONE;
            r_pend_row     <= '0;
            r_pend_operand <= '0;
            r_pend_meta    <= '0;
            r_pend_core    <= '0;
            r_pend_ini     <= '0;
        end else begin
            r_state <= w_state_next;
            // Load data is only on the bank port for one cycle; latch it for hold.
            if (r_data_live) begin
                r_resp.rdata.data <= bank_rdata_i;
                r_data_live       <= 1'b0;
            end
            if (r_out_valid && out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_is_amo) begin
                r_pend_op      <= in_req_i.wdata.amo;
                r_pend_row     <= w_row;
                r_pend_operand <= in_req_i.wdata.data;
                r_pend_meta    <= in_req_i.wdata.meta_id;
                r_pend_core    <= in_req_i.wdata.core_id;
                r_pend_ini     <= in_req_i.ini_addr;
            end
            if (w_accept && (w_is_load || w_is_sc)) begin
                r_out_valid          <= 1'b1;
                r_data_live          <= w_is_load;
                r_resp.ini_addr      <= in_req_i.ini_addr;
                r_resp.rdata.meta_id <= in_req_i.wdata.meta_id;
                r_resp.rdata.core_id <= in_req_i.wdata.core_id;
                r_resp.rdata.amo     <= in_req_i.wdata.amo;
                r_resp.rdata.data    <= w_is_load ? 32'd0 : {31'd0, !w_sc_ok};
            end
            if (r_state == AMO_RD) begin
                r_out_valid          <= 1'b1;
                r_data_live          <= 1'b0;
                r_resp.ini_addr      <= r_pend_ini;
                r_resp.rdata.meta_id <= r_pend_meta;
                r_resp.rdata.core_id <= r_pend_core;
                r_resp.rdata.amo     <= r_pend_op;
                r_resp.rdata.data    <= bank_rdata_i;
            end
        end
    end

    always_comb begin
        out_resp_o = r_resp;
        if (r_data_live) begin
            out_resp_o.rdata.data = bank_rdata_i;
        end
    end

    assign out_valid_o = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_tcdm_amo_shim.sv
// ============================================================================
// Module : tb_tcdm_amo_shim
// Brief  : Directed bench for tcdm_amo_shim against a one-cycle SRAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tcdm_amo_shim;
    import mempool_pkg::*;

    localparam int unsigned SelW = idx_width(NumBanksPerTile);

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, out_valid, out_ready;
    tcdm_slave_req_t  in_req;
    tcdm_slave_resp_t out_resp;
    logic             bank_req, bank_we;
    logic [7:0]       bank_addr;
    logic [31:0]      bank_wdata, bank_rdata;
    logic [3:0]       bank_be;

    logic [31:0] mem [0:255] = '{default: '0};
    int          n_writes = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        acc_req, acc_we;
    logic [7:0]  acc_addr;

    always #5 clk = ~clk;

    tcdm_amo_shim dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_req_i     (in_req),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_resp_o   (out_resp),
        .bank_req_o   (bank_req),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_be_o    (bank_be),
        .bank_rdata_i (bank_rdata)
    );

    always @(posedge clk) begin
        if (bank_req && bank_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bank_be[b]) mem[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
            end
            n_writes++;
        end
        if (bank_req && !bank_we) bank_rdata <= mem[bank_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic tcdm_slave_req_t mk(input logic wen, input logic [3:0] op, input int row,
                                           input logic [31:0] data, input logic [5:0] meta,
                                           input logic [3:0] core, input logic [3:0] ini);
        tcdm_slave_req_t r;
        r                 = '0;
        r.wen             = wen;
        r.be              = 4'hF;
        r.tgt_addr        = tile_addr_t'((row << SelW) | 3);
        r.ini_addr        = ini;
        r.wdata.meta_id   = meta;
        r.wdata.core_id   = core;
        r.wdata.amo       = amo_t'(op);
        r.wdata.data      = data;
        return r;
    endfunction

    // Presents one request, waits (bounded) for acceptance, returns 1ns after the accept edge.
    task automatic do_req(input tcdm_slave_req_t r);
        int waited = 0;
        @(negedge clk);
        in_req   = r;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited == 20) check("accept_timeout", 64'(in_ready), 64'd1);
        acc_req  = bank_req;
        acc_we   = bank_we;
        acc_addr = bank_addr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_req   = '0;
    endtask

    task automatic store(input int row, input logic [31:0] data);
        do_req(mk(1'b1, 4'h0, row, data, 6'h01, 4'h0, 4'h0));
    endtask

    task automatic load_check(input string tag, input int row, input logic [31:0] exp);
        do_req(mk(1'b0, 4'h0, row, 32'h0, 6'h02, 4'h0, 4'h0));
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_resp.rdata.data), 64'(exp));
    endtask

    task automatic amo_check(input string tag, input logic [3:0] op, input int row,
                             input logic [31:0] operand, input logic [31:0] exp_old);
        do_req(mk(1'b0, op, row, operand, 6'h03, 4'h1, 4'h1));
        @(negedge clk);
        check({tag, "_rd_nvalid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_old"}, 64'(out_resp.rdata.data), 64'(exp_old));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tcdm_slave_resp_t snap;
        int               w0;

        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_req    = mk(1'b1, 4'h0, 9, 32'hDEAD_BEEF, 6'h3F, 4'hF, 4'hF);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_resp", 64'(out_resp), 64'd0);
        check("rst_bank_req", 64'(bank_req), 64'd0);
        check("rst_bank_we", 64'(bank_we), 64'd0);
        check("rst_bank_fields", {bank_wdata, 20'd0, bank_be, bank_addr}, 64'd0);
        in_valid = 1'b0;
        in_req   = '0;
        rst      = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Store then load with echoed tags.
        store(3, 32'h0000_0005);
        check("st_bank", {acc_req, acc_we, acc_addr}, {1'b1, 1'b1, 8'd3});
        do_req(mk(1'b0, 4'h0, 3, 32'h0, 6'h15, 4'h2, 4'h9));
        check("ld_bank", {acc_req, acc_we, acc_addr}, {1'b1, 1'b0, 8'd3});
        @(negedge clk);
        check("ld_valid", 64'(out_valid), 64'd1);
        check("ld_data", 64'(out_resp.rdata.data), 64'h5);
        check("ld_echo", {out_resp.rdata.meta_id, out_resp.rdata.core_id, out_resp.ini_addr},
              {6'h15, 4'h2, 4'h9});

        // ADD wrap-around.
        store(3, 32'hFFFF_FFFF);
        amo_check("add", 4'h2, 3, 32'h2, 32'hFFFF_FFFF);
        load_check("add_row", 3, 32'h0000_0001);

        // Signed vs unsigned max/min.
        store(4, 32'h8000_0000);
        amo_check("max", 4'h6, 4, 32'h1, 32'h8000_0000);
        load_check("max_row", 4, 32'h0000_0001);
        store(4, 32'h8000_0000);
        amo_check("maxu", 4'h7, 4, 32'h1, 32'h8000_0000);
        load_check("maxu_row", 4, 32'h8000_0000);
        store(6, 32'hFFFF_FFFE);
        amo_check("min", 4'h8, 6, 32'h5, 32'hFFFF_FFFE);
        load_check("min_row", 6, 32'hFFFF_FFFE);
        amo_check("minu", 4'h9, 6, 32'h5, 32'hFFFF_FFFE);
        load_check("minu_row", 6, 32'h0000_0005);
        amo_check("swap", 4'h1, 6, 32'hCAFE_F00D, 32'h0000_0005);
        load_check("swap_row", 6, 32'hCAFE_F00D);

        // Unassigned op code with wen=1 acts as a plain store.
        do_req(mk(1'b1, 4'hC, 9, 32'h0000_1234, 6'h04, 4'h0, 4'h0));
        check("opC_bank", {acc_req, acc_we, acc_addr}, {1'b1, 1'b1, 8'd9});
        load_check("opC_row", 9, 32'h0000_1234);

        // Response back-pressure on an AMO.
        store(5, 32'h0000_0F0F);
        out_ready = 1'b0;
        w0 = n_writes;
        do_req(mk(1'b0, 4'h5, 5, 32'h0000_00FF, 6'h2A, 4'h3, 4'h7));
        repeat (2) @(negedge clk);
        snap = out_resp;
        check("bp_old", 64'(out_resp.rdata.data), 64'h0000_0F0F);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_stable", 64'(out_resp), 64'(snap));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        check("bp_one_write", 64'(n_writes - w0), 64'd1);
        out_ready = 1'b1;
        load_check("bp_row", 5, 32'h0000_0FF0);

`ifdef TCDM_AMO_LRSC_EN
        store(7, 32'h0000_0000);
        do_req(mk(1'b0, 4'hA, 7, 32'h0, 6'h05, 4'h1, 4'h2));
        do_req(mk(1'b1, 4'hB, 7, 32'h0000_00AA, 6'h06, 4'h1, 4'h2));
        @(negedge clk);
        check("sc_ok_resp", {out_valid, out_resp.rdata.data}, {1'b1, 32'h0});
        load_check("sc_ok_row", 7, 32'h0000_00AA);
        do_req(mk(1'b0, 4'hA, 7, 32'h0, 6'h07, 4'h1, 4'h2));
        store(7, 32'h0000_0055);
        do_req(mk(1'b1, 4'hB, 7, 32'h0000_00BB, 6'h08, 4'h1, 4'h2));
        check("sc_fail_nobank", 64'(acc_req), 64'd0);
        @(negedge clk);
        check("sc_fail_resp", {out_valid, out_resp.rdata.data}, {1'b1, 32'h1});
        load_check("sc_fail_row", 7, 32'h0000_0055);
`else
        store(7, 32'h0000_0055);
        do_req(mk(1'b0, 4'hA, 7, 32'h0, 6'h05, 4'h1, 4'h2));
        @(negedge clk);
        check("lr_load", {out_valid, out_resp.rdata.data}, {1'b1, 32'h55});
        do_req(mk(1'b1, 4'hB, 7, 32'h0000_00AA, 6'h06, 4'h1, 4'h2));
        check("sc_nobank", 64'(acc_req), 64'd0);
        @(negedge clk);
        check("sc_resp", {out_valid, out_resp.rdata.data}, {1'b1, 32'h1});
        load_check("sc_row", 7, 32'h0000_0055);
`endif

        // Reset during the AMO read cycle drops the write phase.
        store(8, 32'h0000_0010);
        w0 = n_writes;
        do_req(mk(1'b0, 4'h2, 8, 32'h1, 6'h09, 4'h0, 4'h0));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bank_we", 64'(bank_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_no_write", 64'(n_writes - w0), 64'd0);
        load_check("mid_rst_row", 8, 32'h0000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tcdm_amo_shim.md
TCDM_AMO_SHIM -- requirements
Module: tcdm_amo_shim

Interface
REQ-001 SHALL have one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-002 SHALL have parameter BankRowWidth, default TCDMAddrMemWidth, the SRAM row address width.
REQ-003 SHALL have parameter BankSelWidth, default idx_width(NumBanksPerTile), the tile_addr_t bank-select bits stripped off.
REQ-004 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted
- in_req_i  in  tcdm_slave_req_t  request from the group interconnect
- out_valid_o  out  1  response valid
- out_ready_i  in  1  response consumed
- out_resp_o  out  tcdm_slave_resp_t  response
- bank_req_o  out  1  SRAM access
- bank_we_o  out  1  SRAM write
- bank_addr_o  out  BankRowWidth  SRAM row
- bank_wdata_o  out  32  SRAM write data
- bank_be_o  out  4  SRAM byte enables
- bank_rdata_i  in  32  SRAM read data, valid one cycle after a read

Function
REQ-005 SHALL derive row = tgt_addr >> BankSelWidth, truncated to BankRowWidth.
REQ-006 amo_t encoding: 0 none, 1 SWAP, 2 ADD, 3 AND, 4 OR, 5 XOR, 6 MAX, 7 MAXU, 8 MIN, 9 MINU, A LR, B SC; B..F other than B SHALL be treated as none.
REQ-007 FSM states: IDLE, AMO_RD, RESP_HOLD.
REQ-008 in_ready_o SHALL be 1 only in IDLE with the response register empty or draining (out_ready_i=1).
REQ-009 Plain load (wen=0, amo=0):
- bank read in the accept cycle.
- out_valid_o next cycle.
- rdata.data = bank_rdata_i.
- meta_id, core_id, amo and ini_addr echoed.
REQ-010 Plain store (wen=1, amo=0): bank write with be in the accept cycle; no response.
REQ-011 AMO ops 1–9: accept cycle issues a full-word read and goes to AMO_RD. Next cycle SHALL:
- write f(old, wdata) with be=4'hF;
- load the response with the old value;
- return to IDLE.
Accept-to-response latency is 2 cycles.
REQ-012 Arithmetic SHALL be 32-bit with ADD wrap-around. MAX/MIN SHALL be signed and MAXU/MINU unsigned.
REQ-013 While out_valid_o=1 and out_ready_i=0, the response SHALL hold stable. A new result SHALL NOT be produced: the FSM waits in RESP_HOLD and the captured bank data is kept in a register.
REQ-014 At most one request SHALL be in flight; the shim never issues a bank access while a response is pending and undrained.

Reset
REQ-015 Reset SHALL force:
- FSM to IDLE;
- out_valid_o=0, out_resp_o='0;
- bank_req_o=0, bank_we_o=0, bank_addr_o=0, bank_wdata_o=0, bank_be_o=0;
- reservation invalid.
REQ-016 Reset mid-AMO SHALL abandon the write phase; no bank write occurs after reset assertion.

Configuration
REQ-017 With TCDM_AMO_LRSC_EN defined, a single reservation (valid, row, ini_addr, core_id) SHALL be kept:
- LR reads like a load and sets the reservation.
- SC succeeds only if valid and all three fields match: it writes wdata and responds 0. Otherwise there is no write and it responds 1.
- Any SC clears the reservation.
- Any store or AMO write to the reserved row clears it.
- A new LR overwrites it.
REQ-018 Without TCDM_AMO_LRSC_EN, LR SHALL behave as a plain load and SC SHALL never write and respond 1; no reservation state SHALL be instantiated.

Structure
REQ-019 The amo_t encoding constants and the reservation struct type SHALL live in mempool_pkg; tcdm_slave_req_t/resp_t are reused unchanged.
REQ-020 The ALU SHALL be a combinational sub-module tcdm_amo_alu (op, old, operand -> result); the FSM and reservation stay in tcdm_amo_shim.

Verification
REQ-021 Store 0x0000_0005 row 3, then load row 3 -> response data 0x5 one cycle after accept, with meta_id/ini_addr echoed.
REQ-022 Row 3 = 0xFFFF_FFFF, AMO ADD 2 -> response 0xFFFF_FFFF two cycles after accept; row 3 then reads 0x0000_0001.
REQ-023 Row 4 = 0x8000_0000:
- MAX with 1 -> row 4 = 0x1.
- Restore 0x8000_0000; MAXU with 1 -> row 4 unchanged.
REQ-024 AMO response with out_ready_i=0 for 5 cycles:
- out_resp_o stays stable;
- in_ready_o=0;
- exactly one bank write occurs.
REQ-025 With TCDM_AMO_LRSC_EN:
- LR row 7 (core 1, ini 2); SC 0xAA same ID -> response 0, row 7 = 0xAA.
- Repeat with an intervening store to row 7 -> SC responds 1 and row 7 keeps the store data.
REQ-026 Assert rst_i in the AMO_RD cycle -> no bank write, out_valid_o=0, in_ready_o=1 after release.
